// File: rtl/vu_frame_tracker.sv
// rtl/vu_frame_tracker.sv - framed multi-channel level parser with per-channel peak-hold and decay
module vu_frame_tracker #(
    parameter int          CH_NO       = 16,
    parameter int          LW          = 4,
    parameter int          HOLD_FRAMES = 8,
    parameter int          TIMEOUT_CYC = 65535,
    parameter logic [7:0]  SYNC_BYTE   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_in,
    input  logic                  valid,
    input  logic                  mode,
    output logic [CH_NO*LW-1:0]   level_out,
    output logic [CH_NO*LW-1:0]   peak_out,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int IW = (CH_NO > 1) ? $clog2(CH_NO) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_tmo;
    logic [LW-1:0]   r_shadow [CH_NO];
    logic [LW-1:0]   r_level  [CH_NO];
    logic [LW-1:0]   r_peak   [CH_NO];
    logic [HW-1:0]   r_hold   [CH_NO];
    logic            r_done;
    logic            r_err;

    logic            w_sync;
    logic            w_data;
    logic            w_last;
    logic            w_tmo_hit;
    logic            w_store;
    logic            w_resync;
    logic            w_abort;
    logic            w_commit;
    logic            w_start;

    // Byte classification; data bytes are assumed never to equal the sync byte
    always_comb begin
        w_sync    = valid && (data_in == SYNC_BYTE);
        w_data    = valid && (data_in != SYNC_BYTE);
        w_last    = (r_idx == IW'(CH_NO - 1));
        w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next   = r_state;
        w_store  = 1'b0;
        w_resync = 1'b0;
        w_abort  = 1'b0;
        w_commit = 1'b0;
        w_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sync) begin
                    w_next  = S_RECV;
                    w_start = 1'b1;
                end
            end
            S_RECV: begin
                if (w_sync) begin
                    w_resync = 1'b1;
                end else if (w_data) begin
                    w_store = 1'b1;
                    if (w_last) begin
                        w_next = S_COMMIT;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_COMMIT: begin
                // A byte landing on the commit cycle is treated as if idle
                w_commit = 1'b1;
                if (w_sync) begin
                    w_next  = S_RECV;
                    w_start = 1'b1;
                end else begin
                    w_next  = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Channel index: restarts on every header, advances on each stored data byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_start || w_resync) begin
            r_idx <= '0;
        end else if (w_store) begin
            r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
    end

    // Idle-cycle counter, only meaningful while receiving; any valid byte restarts it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo <= '0;
        end else if (valid || (r_state != S_RECV) || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Shadow buffer collects the frame so outputs only ever show whole frames
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH_NO; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_resync) begin
            for (int i = 0; i < CH_NO; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_store) begin
            r_shadow[r_idx] <= data_in[7 -: LW];
        end
    end

    // Commit: publish levels and advance every channel's peak-hold in parallel
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH_NO; i++) begin
                r_level[i] <= '0;
                r_peak[i]  <= '0;
                r_hold[i]  <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < CH_NO; i++) begin
                r_level[i] <= r_shadow[i];
                if (!mode) begin
                    r_peak[i] <= r_shadow[i];
                    r_hold[i] <= '0;
                end else if (r_shadow[i] >= r_peak[i]) begin
                    r_peak[i] <= r_shadow[i];
                    r_hold[i] <= HW'(HOLD_FRAMES);
                end else if (r_hold[i] != '0) begin
                    r_hold[i] <= r_hold[i] - HW'(1);
                end else begin
                    // Here the new level is strictly below peak, so peak-1 never undershoots it
                    r_peak[i] <= r_peak[i] - LW'(1);
                end
            end
        end
    end

    // Status strobes; commit and abort come from different states so they never overlap
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_err  <= w_resync || w_abort;
        end
    end

    // Pack per-channel registers onto the flat output vectors
    for (genvar g = 0; g < CH_NO; g++) begin : g_pack
        assign level_out[g*LW +: LW] = r_level[g];
        assign peak_out[g*LW +: LW]  = r_peak[g];
    end

    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_vu_frame_tracker.sv
// tb/tb_vu_frame_tracker.sv - scoreboard bench for vu_frame_tracker
module tb_vu_frame_tracker;

    localparam int CH = 4;
    localparam int LW = 4;
    localparam int VW = CH * LW;
    localparam int HOLD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          valid = 1'b0;
    logic          mode = 1'b1;
    logic [VW-1:0] level_out;
    logic [VW-1:0] peak_out;
    logic          frame_done;
    logic          frame_err;

    vu_frame_tracker #(
        .CH_NO(CH), .LW(LW), .HOLD_FRAMES(HOLD), .TIMEOUT_CYC(64), .SYNC_BYTE(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .mode(mode),
        .level_out(level_out), .peak_out(peak_out),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          kind;
        logic [VW-1:0] lv;
        logic [VW-1:0] pk;
    } ev_t;

    ev_t           sb[$];
    int            n_assert = 0;
    int            n_fail = 0;
    logic [3:0]    m_peak [CH];
    logic [7:0]    m_hold [CH];
    logic [VW-1:0] m_level = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pk_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < CH; i++) v[i*LW +: LW] = m_peak[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_peak[i] = '0;
            m_hold[i] = '0;
        end
        m_level = '0;
    endtask

    task automatic model_commit(input logic [VW-1:0] lv);
        logic [3:0] l;
        for (int i = 0; i < CH; i++) begin
            l = lv[i*LW +: LW];
            if (!mode) begin
                m_peak[i] = l; m_hold[i] = 0;
            end else if (l >= m_peak[i]) begin
                m_peak[i] = l; m_hold[i] = HOLD;
            end else if (m_hold[i] > 0) begin
                m_hold[i] = m_hold[i] - 1;
            end else if (m_peak[i] > l) begin
                m_peak[i] = m_peak[i] - 1;
            end
        end
        m_level = lv;
        sb.push_back({1'b1, lv, pk_vec()});
    endtask

    task automatic push_err();
        sb.push_back({1'b0, m_level, pk_vec()});
    endtask

    task automatic send(input logic [7:0] b);
        data_in = b;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send(8'hFF);
        send(a);
        send(b);
        send(c);
        model_commit({d[7:4], c[7:4], b[7:4], a[7:4]});
        send(d);
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (rst && (frame_done || frame_err)) begin
            ev_t e;
            check("strobe_excl", 32'(frame_done & frame_err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'({frame_done, frame_err}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 32'(frame_done), 32'(e.kind));
                check("sb_level", 32'(level_out), 32'(e.lv));
                check("sb_peak", 32'(peak_out), 32'(e.pk));
            end
        end
    end

    initial begin
        model_reset();

        // 1: reset held with random traffic
        rst = 1'b0;
        repeat (3) begin
            valid   = 1'($urandom);
            data_in = 8'($urandom);
            @(negedge clk);
            check("rst_level", 32'(level_out), 32'd0);
            check("rst_peak", 32'(peak_out), 32'd0);
            check("rst_strobes", 32'({frame_done, frame_err}), 32'd0);
        end
        valid = 1'b0;
        rst   = 1'b1;
        idle(2);

        // 2: first frame, exact commit latency and single-cycle pulse
        frame(8'h10, 8'h80, 8'hF0, 8'h00);
        check("lat_done_early", 32'(frame_done), 32'd0);
        check("lat_level_early", 32'(level_out), 32'd0);
        @(negedge clk);
        check("lat_done", 32'(frame_done), 32'd1);
        check("s2_level", 32'(level_out), 32'h0F81);
        check("s2_peak", 32'(peak_out), 32'h0F81);
        @(negedge clk);
        check("done_pulse_width", 32'(frame_done), 32'd0);

        // 3: hold then decay; first two frames back to back (header on commit cycle)
        frame(8'h00, 8'h00, 8'h00, 8'h00);
        frame(8'h00, 8'h00, 8'h00, 8'h00);
        idle(2);
        check("s3_hold_peak", 32'(peak_out), 32'h0F81);
        check("s3_hold_level", 32'(level_out), 32'h0000);
        frame(8'h00, 8'h00, 8'h00, 8'h00);
        idle(2);
        check("s3_decay1", 32'(peak_out), 32'h0E70);
        frame(8'h00, 8'h00, 8'h00, 8'h00);
        idle(2);
        check("s3_decay2", 32'(peak_out), 32'h0D60);

        // 4: resync mid-frame
        send(8'hFF);
        send(8'h10);
        send(8'h20);
        push_err();
        send(8'hFF);
        check("s4_err_pulse", 32'(frame_err), 32'd1);
        send(8'h30);
        send(8'h40);
        send(8'h50);
        model_commit(16'h6543);
        send(8'h60);
        idle(2);
        check("s4_level", 32'(level_out), 32'h6543);

        // 5: timeout, ignored stray byte, recovery
        send(8'hFF);
        send(8'h10);
        idle(63);
        check("s5_no_err_early", 32'(frame_err), 32'd0);
        push_err();
        idle(1);
        check("s5_timeout_err", 32'(frame_err), 32'd1);
        check("s5_level_kept", 32'(level_out), 32'h6543);
        send(8'h20);
        idle(3);
        check("s5_stray_ignored", 32'(level_out), 32'h6543);
        frame(8'h11, 8'h22, 8'h33, 8'h44);
        idle(2);
        check("s5_level", 32'(level_out), 32'h4321);

        // 6: reset mid-frame, then raw mode
        send(8'hFF);
        send(8'h10);
        send(8'h20);
        rst = 1'b0;
        @(negedge clk);
        check("s6_rst_level", 32'(level_out), 32'd0);
        check("s6_rst_peak", 32'(peak_out), 32'd0);
        check("s6_rst_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        model_reset();
        mode = 1'b0;
        frame(8'h90, 8'h00, 8'h00, 8'h00);
        idle(2);
        check("s6_level", 32'(level_out), 32'h0009);
        check("s6_peak", 32'(peak_out), 32'h0009);

        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vu_frame_tracker.md
Name: vu_frame_tracker

Overview:
- Parametrised successor to the single-stream byte capture path of the VU meter.
- Consumes the UART byte stream (data byte plus one-cycle valid strobe, already in the system clock domain) and parses framed multi-channel level packets.
- Converts each channel sample to a bar level and keeps a per-channel peak-hold with timed decay.
- Presents packed level and peak vectors, plus frame status strobes, to the VGA renderer.

Parameters:
- CH_NO, 16, number of channels per frame (2..32).
- LW, 4, bar level width in bits; level = top LW bits of the sample byte (1..8).
- HOLD_FRAMES, 8, number of frames a new peak is held before decay starts (1..255).
- TIMEOUT_CYC, 65535, idle clk cycles inside a frame before the frame is aborted (>=2).
- SYNC_BYTE, 8'hFF, frame header byte.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous active-low reset.
- data_in  in  8  received byte.
- valid  in  1  one-cycle strobe; data_in is sampled only when valid=1.
- mode  in  1  0 = raw (peak follows level); 1 = peak-hold with decay.
- level_out  out  CH_NO*LW  committed levels; channel i is at bits [i*LW +: LW].
- peak_out  out  CH_NO*LW  peak levels, same packing as level_out.
- frame_done  out  1  one-cycle pulse when a frame commits.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: one clock, synchronous, active-low.
  - rst=0 at a rising edge clears level_out, peak_out, all hold counters, the shadow buffer, the channel index and the timeout counter.
  - frame_done=0, frame_err=0, state=IDLE.
  - Reset mid-frame discards the partial frame without asserting frame_err.
- Framing: one frame is SYNC_BYTE followed by CH_NO data bytes, channel 0 first. Senders restrict data bytes to values != SYNC_BYTE.
- IDLE:
  - valid with data_in==SYNC_BYTE -> RECV, idx=0, timeout counter cleared.
  - Any other byte is ignored.
- RECV, valid with a data byte:
  - shadow[idx] = data_in[7 -: LW].
  - If idx==CH_NO-1 -> COMMIT; otherwise idx+1.
- RECV, valid with SYNC_BYTE (resync):
  - frame_err pulses on the next cycle.
  - Shadow contents are discarded; idx=0; state stays RECV.
- RECV timeout:
  - The timeout counter increments every cycle without valid and clears on every valid.
  - When it reaches TIMEOUT_CYC: frame_err pulses, state -> IDLE, outputs are unchanged.
- COMMIT (exactly one cycle). At the edge ending it:
  - level_out <= shadow.
  - frame_done=1 for that following cycle.
  - Peaks update for every channel in parallel (see peak rules).
  - A valid byte arriving during COMMIT is handled with the IDLE rules.
- Latency: last data byte sampled at edge k -> level_out, peak_out and frame_done all change at edge k+1 (the COMMIT edge). frame_done is high from edge k+1 to edge k+2.
- Peak rules at COMMIT, per channel with new level L:
  - mode=0: peak=L, hold=0.
  - mode=1, L>=peak: peak=L, hold=HOLD_FRAMES.
  - mode=1, L<peak, hold>0: hold=hold-1, peak is unchanged.
  - mode=1, L<peak, hold==0: peak=peak-1, never below L. This is unsigned with no wrap.
- Decay advances only on committed frames. Aborted frames and timeouts leave peaks and hold counters untouched.
- A mode change takes effect at the next COMMIT. A 1->0 change snaps peak to level at that commit.
- Invariant: peak_out channel >= level_out channel whenever mode=1, from the first commit onward.
- frame_done and frame_err are never high in the same cycle.

Test Plan:
Bench configuration: CH_NO=4, LW=4, HOLD_FRAMES=2, TIMEOUT_CYC=64, mode=1 unless stated.
1. Reset hold of 3 cycles with random valid/data -> level_out=0, peak_out=0, no strobes, state IDLE.
2. Bytes FF,10,80,F0,00 -> at the edge after the 00 byte, level_out channels = 1,8,F,0 and peak_out = 1,8,F,0; frame_done is a single 1-cycle pulse.
3. After scenario 2, send frames FF,00,00,00,00 four times:
   - Frames 1-2: peaks stay 1,8,F,0 while levels are 0.
   - Frame 3: peaks = 0,7,E,0.
   - Frame 4: peaks = 0,6,D,0.
4. FF,10,20,FF,30,40,50,60 -> one frame_err pulse the cycle after the second FF, then level_out = 3,4,5,6; no commit of 1,2.
5. FF,10, then 64 idle cycles -> frame_err pulse, state IDLE, outputs unchanged. A following lone 20 is ignored. FF,11,22,33,44 then commits levels 1,2,3,4.
6. Assert rst=0 after FF,10,20 -> all outputs are zero at the next edge and no frame_err. Then mode=0 with frame FF,90,00,00,00 -> peak_out = level_out = 9,0,0,0.
